// File: rtl/td4_pkg.sv
// Shared opcodes, ALU source encoding and decoded-control struct for the
// parametrised TD4 accumulator core.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_HALT   = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_IN   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  typedef struct packed {
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       ld_pc_jmp;
    logic       is_jnc;
    logic       is_halt;
    logic [1:0] sel;
  } ctrl_t;

endpackage

// File: rtl/td4_decode.sv
// Combinational opcode decoder: OP -> register load enables, jump/halt flags
// and adder source select. Unlisted opcodes decode as NOP.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl     = '0;
    ctrl.sel = SEL_ZERO;
    unique case (op)
      OP_ADD_A:  begin ctrl.ld_a = 1'b1; ctrl.sel = SEL_A;  end
      OP_MOV_AB: begin ctrl.ld_a = 1'b1; ctrl.sel = SEL_B;  end
      OP_IN_A:   begin ctrl.ld_a = 1'b1; ctrl.sel = SEL_IN; end
      OP_MOV_AI: ctrl.ld_a = 1'b1;
      OP_MOV_BA: begin ctrl.ld_b = 1'b1; ctrl.sel = SEL_A;  end
      OP_ADD_B:  begin ctrl.ld_b = 1'b1; ctrl.sel = SEL_B;  end
      OP_IN_B:   begin ctrl.ld_b = 1'b1; ctrl.sel = SEL_IN; end
      OP_MOV_BI: ctrl.ld_b = 1'b1;
      OP_HALT:   ctrl.is_halt = 1'b1;
      OP_OUT_B:  begin ctrl.ld_out = 1'b1; ctrl.sel = SEL_B; end
      OP_OUT_I:  ctrl.ld_out = 1'b1;
      OP_JNC:    ctrl.is_jnc = 1'b1;
      OP_JMP:    ctrl.ld_pc_jmp = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_core_param.sv
// Single-cycle TD4 accumulator core with generic data/address width,
// external instruction ROM port, run-enable stall and sticky HALT.
module td4_core_param
  import td4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              EN,
  output logic [ADDR_W-1:0] IADDR,
  input  logic [DATA_W+3:0] IDATA,
  input  logic [DATA_W-1:0] IN_PORT,
  output logic [DATA_W-1:0] OUT_PORT,
  output logic              CARRY,
  output logic              HALTED
);

  if (ADDR_W > DATA_W) begin : g_bad_width
    $error("td4_core_param: ADDR_W must not exceed DATA_W");
  end

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] a, b, im, sel_val;
  logic [DATA_W:0]   sum;
  logic              exec, take_jmp;
  ctrl_t             ctrl;

  assign IADDR = pc;
  assign im    = IDATA[DATA_W-1:0];

  td4_decode u_decode (
    .op   (IDATA[DATA_W+3:DATA_W]),
    .ctrl (ctrl)
  );

  always_comb begin
    sel_val = '0;
    unique case (ctrl.sel)
      SEL_A:   sel_val = a;
      SEL_B:   sel_val = b;
      SEL_IN:  sel_val = IN_PORT;
      default: sel_val = '0;
    endcase
  end

  assign sum      = {1'b0, sel_val} + {1'b0, im};
  assign exec     = EN && !HALTED;
  // JNC looks at the carry left by the previous instruction
  assign take_jmp = ctrl.ld_pc_jmp || (ctrl.is_jnc && !CARRY);

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      pc       <= '0;
      a        <= '0;
      b        <= '0;
      OUT_PORT <= '0;
      CARRY    <= 1'b0;
      HALTED   <= 1'b0;
    end else if (exec) begin
      CARRY <= sum[DATA_W];
      if (ctrl.ld_a)   a        <= sum[DATA_W-1:0];
      if (ctrl.ld_b)   b        <= sum[DATA_W-1:0];
      if (ctrl.ld_out) OUT_PORT <= sum[DATA_W-1:0];
      if (ctrl.is_halt)  HALTED <= 1'b1;
      else if (take_jmp) pc     <= im[ADDR_W-1:0];
      else               pc     <= pc + ADDR_W'(1);
    end
  end

endmodule
